// File: rtl/mux_n_1_pkg.sv
// Shared types and constants for the registered N:1 multiplexer.
package mux_n_1_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_GAP = 1'b1
    } mux_state_e;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N:1 selector; an out-of-range select yields zero.
module mux_n_comb #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [CH_NUM*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data
);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < int'(CH_NUM); k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_n_1.sv
// Registered N:1 multiplexer with valid/ready channel select and blanking on switch.
module mux_n_1
    import mux_n_1_pkg::*;
#(
    parameter int unsigned        CH_NUM   = 4,
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        SEL_W    = 2,
    parameter int unsigned        GAP_CYC  = 2,
    parameter logic [DATA_W-1:0]  IDLE_VAL = '0
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [CH_NUM*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     sel_vld,
    output logic                     sel_rdy,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_vld,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     sel_err
);

    localparam logic [31:0]      ChNum   = 32'(CH_NUM);
    localparam logic [CNT_W-1:0] GapLoad = (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);

    mux_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SEL_W-1:0]  cur_sel_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_vld_q;
    logic              sel_err_q;

    logic              accept;
    logic              in_range;
    logic              do_switch;
    logic [SEL_W-1:0]  mux_sel;
    logic [DATA_W-1:0] mux_data;

    assign sel_rdy   = (state_q == ST_RUN);
    assign accept    = sel_vld && sel_rdy;
    assign in_range  = (32'(sel_in) < ChNum);
    assign do_switch = accept && in_range && (sel_in != cur_sel_q);
    // A zero-gap switch must show the new channel on the accepting edge itself.
    assign mux_sel   = do_switch ? sel_in : cur_sel_q;

    mux_n_comb #(
        .CH_NUM (CH_NUM),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data  (in_data),
        .sel      (mux_sel),
        .out_data (mux_data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            cur_sel_q  <= '0;
            out_data_q <= IDLE_VAL;
            out_vld_q  <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            sel_err_q <= 1'b0;
            if (state_q == ST_GAP) begin
                if (cnt_q != '0) begin
                    cnt_q      <= cnt_q - CNT_W'(1);
                    out_data_q <= IDLE_VAL;
                    out_vld_q  <= 1'b0;
                end else begin
                    state_q    <= ST_RUN;
                    out_data_q <= mux_data;
                    out_vld_q  <= 1'b1;
                end
            end else if (accept && !in_range) begin
                sel_err_q  <= 1'b1;
                out_data_q <= mux_data;
                out_vld_q  <= 1'b1;
            end else if (do_switch && (GAP_CYC != 0)) begin
                cur_sel_q  <= sel_in;
                cnt_q      <= GapLoad;
                out_data_q <= IDLE_VAL;
                out_vld_q  <= 1'b0;
                state_q    <= ST_GAP;
            end else begin
                if (do_switch) begin
                    cur_sel_q <= sel_in;
                end
                out_data_q <= mux_data;
                out_vld_q  <= 1'b1;
            end
        end
    end

    assign out_data = out_data_q;
    assign out_vld  = out_vld_q;
    assign cur_sel  = cur_sel_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_mux_n_1.sv
// Bench for mux_n_1: three configurations checked against a cycle model plus literal pins.
module tb_mux_n_1;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [1:0]  sel_a  [3];
    logic        vld_a  [3];
    logic [7:0]  od     [3];
    logic        ov     [3];
    logic        rdy    [3];
    logic        err    [3];
    logic [1:0]  cs     [3];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Per-instance configuration: main (N=4,G=2), zero gap (N=4,G=0), three channels (N=3,G=2).
    int unsigned g_cyc [3] = '{2, 0, 2};
    int unsigned n_ch  [3] = '{4, 4, 3};

    // Model state: blank counts remaining low-valid cycles.
    int unsigned m_cur   [3];
    int unsigned m_blank [3];
    logic [7:0]  m_out   [3];
    logic        m_vld   [3];
    logic        m_err   [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_n_1 #(.CH_NUM(4), .DATA_W(8), .SEL_W(2), .GAP_CYC(2), .IDLE_VAL(8'h00)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data), .sel_in(sel_a[0]),
        .sel_vld(vld_a[0]), .sel_rdy(rdy[0]), .out_data(od[0]), .out_vld(ov[0]),
        .cur_sel(cs[0]), .sel_err(err[0])
    );
    mux_n_1 #(.CH_NUM(4), .DATA_W(8), .SEL_W(2), .GAP_CYC(0), .IDLE_VAL(8'h00)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data), .sel_in(sel_a[1]),
        .sel_vld(vld_a[1]), .sel_rdy(rdy[1]), .out_data(od[1]), .out_vld(ov[1]),
        .cur_sel(cs[1]), .sel_err(err[1])
    );
    mux_n_1 #(.CH_NUM(3), .DATA_W(8), .SEL_W(2), .GAP_CYC(2), .IDLE_VAL(8'h00)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data[23:0]), .sel_in(sel_a[2]),
        .sel_vld(vld_a[2]), .sel_rdy(rdy[2]), .out_data(od[2]), .out_vld(ov[2]),
        .cur_sel(cs[2]), .sel_err(err[2])
    );

    function automatic logic [7:0] chan(int unsigned k);
        return in_data[k*8 +: 8];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_cur[i] <= 0; m_blank[i] <= 0; m_out[i] <= 8'h00;
                m_vld[i] <= 1'b0; m_err[i] <= 1'b0;
            end else begin
                m_err[i] <= 1'b0;
                if (m_blank[i] > 0) begin
                    m_blank[i] <= m_blank[i] - 1;
                    m_out[i]   <= (m_blank[i] == 1) ? chan(m_cur[i]) : 8'h00;
                    m_vld[i]   <= (m_blank[i] == 1);
                end else if (vld_a[i] && sel_a[i] >= n_ch[i]) begin
                    m_err[i] <= 1'b1;
                    m_out[i] <= chan(m_cur[i]);
                    m_vld[i] <= 1'b1;
                end else if (vld_a[i] && sel_a[i] != m_cur[i]) begin
                    m_cur[i]   <= sel_a[i];
                    m_blank[i] <= g_cyc[i];
                    m_out[i]   <= (g_cyc[i] == 0) ? chan(sel_a[i]) : 8'h00;
                    m_vld[i]   <= (g_cyc[i] == 0);
                end else begin
                    m_out[i] <= chan(m_cur[i]);
                    m_vld[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("m%0d_data", i), 32'(od[i]), 32'(m_out[i]));
            check($sformatf("m%0d_vld", i), 32'(ov[i]), 32'(m_vld[i]));
            check($sformatf("m%0d_cur", i), 32'(cs[i]), m_cur[i]);
            check($sformatf("m%0d_err", i), 32'(err[i]), 32'(m_err[i]));
            check($sformatf("m%0d_rdy", i), 32'(rdy[i]), 32'(m_blank[i] == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(string name, int i, logic [7:0] d, logic v, logic r, logic [1:0] c,
                       logic e);
        check({name, "_data"}, 32'(od[i]), 32'(d));
        check({name, "_vld"}, 32'(ov[i]), 32'(v));
        check({name, "_rdy"}, 32'(rdy[i]), 32'(r));
        check({name, "_cur"}, 32'(cs[i]), 32'(c));
        check({name, "_err"}, 32'(err[i]), 32'(e));
    endtask

    initial begin
        rst_n   = 1'b0;
        in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < 3; i++) begin
            sel_a[i] = 2'd0;
            vld_a[i] = 1'b0;
        end
        #22;
        pin("in_reset", 0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
        #4 rst_n = 1'b1;
        tick();
        pin("first_out", 0, 8'hAA, 1'b1, 1'b1, 2'd0, 1'b0);

        sel_a[0] = 2'd2; vld_a[0] = 1'b1;
        sel_a[1] = 2'd3; vld_a[1] = 1'b1;
        sel_a[2] = 2'd3; vld_a[2] = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) vld_a[i] = 1'b0;
        pin("gap1", 0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0);
        pin("g0_sw", 1, 8'hDD, 1'b1, 1'b1, 2'd3, 1'b0);
        pin("oor_err", 2, 8'hAA, 1'b1, 1'b1, 2'd0, 1'b1);
        tick();
        pin("gap2", 0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0);
        pin("oor_done", 2, 8'hAA, 1'b1, 1'b1, 2'd0, 1'b0);
        tick();
        pin("gap_end", 0, 8'hCC, 1'b1, 1'b1, 2'd2, 1'b0);

        sel_a[0] = 2'd2; vld_a[0] = 1'b1;
        sel_a[2] = 2'd0; vld_a[2] = 1'b1;
        tick();
        vld_a[0] = 1'b0; vld_a[2] = 1'b0;
        pin("same_sel", 0, 8'hCC, 1'b1, 1'b1, 2'd2, 1'b0);
        pin("same_sel0", 2, 8'hAA, 1'b1, 1'b1, 2'd0, 1'b0);

        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        pin("latency", 0, 8'h33, 1'b1, 1'b1, 2'd2, 1'b0);
        pin("latency_g0", 1, 8'h44, 1'b1, 1'b1, 2'd3, 1'b0);
        in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        tick();

        sel_a[0] = 2'd1; vld_a[0] = 1'b1;
        tick();
        vld_a[0] = 1'b0;
        pin("sw1_gap1", 0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        pin("mid_gap_rst", 0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        pin("after_rst", 0, 8'hAA, 1'b1, 1'b1, 2'd0, 1'b0);
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
